// File: rtl/halloween_show_sequencer.sv
// Show sequencer for the decoration channel bank: on a trigger it steps a 4-bit
// channel select through a chase, bounce or LFSR pattern with a programmable dwell.
module halloween_show_sequencer #(
    parameter int          DWELL_W   = 8,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [4:0]         steps,
    output logic [3:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    state_t             state;
    logic [1:0]         mode_l;
    logic [DWELL_W-1:0] dwell_l;
    logic [4:0]         steps_l;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [4:0]         step_cnt;
    logic [7:0]         lfsr;
    logic [7:0]         lfsr_next;
    logic               dir_down;

    // x^8+x^6+x^5+x^4+1, shifting left; a nonzero seed can never reach zero
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 4'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_l    <= 2'b00;
            dwell_l   <= DWELL_ONE;
            steps_l   <= 5'd16;
            dwell_cnt <= '0;
            step_cnt  <= 5'd0;
            lfsr      <= LFSR_SEED;
            dir_down  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (trigger) begin
                        state     <= RUN;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        mode_l    <= mode;
                        dwell_l   <= (dwell == '0) ? DWELL_ONE : dwell;
                        steps_l   <= (steps == 5'd0) ? 5'd16 : steps;
                        dwell_cnt <= '0;
                        step_cnt  <= 5'd0;
                        dir_down  <= 1'b0;
                        case (mode)
                            2'b00:   sel <= 4'd0;
                            2'b01:   sel <= 4'd15;
                            2'b10:   sel <= 4'd0;
                            default: begin
                                sel  <= lfsr_next[3:0];
                                lfsr <= lfsr_next;
                            end
                        endcase
                    end
                end

                RUN: begin
                    // abort wins over a step event landing in the same cycle
                    if (abort) begin
                        state     <= IDLE;
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (dwell_cnt == dwell_l - DWELL_ONE) begin
                        dwell_cnt <= '0;
                        if (step_cnt == steps_l - 5'd1) begin
                            state     <= DONE;
                            sel_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            step_cnt <= step_cnt + 5'd1;
                            case (mode_l)
                                2'b00:   sel <= sel + 4'd1;
                                2'b01:   sel <= sel - 4'd1;
                                2'b10: begin
                                    if (!dir_down) begin
                                        if (sel == 4'd15) begin
                                            sel      <= 4'd14;
                                            dir_down <= 1'b1;
                                        end else begin
                                            sel <= sel + 4'd1;
                                        end
                                    end else begin
                                        if (sel == 4'd0) begin
                                            sel      <= 4'd1;
                                            dir_down <= 1'b0;
                                        end else begin
                                            sel <= sel - 4'd1;
                                        end
                                    end
                                end
                                default: begin
                                    sel  <= lfsr_next[3:0];
                                    lfsr <= lfsr_next;
                                end
                            endcase
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_ONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    sel_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halloween_show_sequencer.sv
// Directed bench for halloween_show_sequencer: drives shows on the falling edge
// and compares outputs against hand-computed channel sequences.
module tb_halloween_show_sequencer;

    logic       clk;
    logic       rst_n;
    logic       trigger;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [4:0] steps;
    logic [3:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;

    int checks;
    int errors;
    int exp_q[$];
    logic [7:0] lfsr_model;

    halloween_show_sequencer #(
        .DWELL_W   (8),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .trigger   (trigger),
        .abort     (abort),
        .mode      (mode),
        .dwell     (dwell),
        .steps     (steps),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsrAdvance(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic checkOutput(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the first RUN cycle
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] d, input logic [4:0] s);
        mode    = m;
        dwell   = d;
        steps   = s;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic expectShow(input int dw);
        foreach (exp_q[i]) begin
            for (int k = 0; k < dw; k++) begin
                checkOutput("sel", int'(sel), exp_q[i]);
                checkOutput("sel_valid_run", int'(sel_valid), 1);
                checkOutput("busy_run", int'(busy), 1);
                checkOutput("done_run", int'(done), 0);
                @(negedge clk);
            end
        end
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("busy_done", int'(busy), 1);
        checkOutput("sel_valid_done", int'(sel_valid), 0);
        @(negedge clk);
        checkOutput("done_cleared", int'(done), 0);
        checkOutput("busy_idle", int'(busy), 0);
        checkOutput("sel_valid_idle", int'(sel_valid), 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        trigger = 1'b0;
        abort   = 1'b0;
        mode    = 2'b00;
        dwell   = 8'd0;
        steps   = 5'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_sel", int'(sel), 0);
        checkOutput("reset_sel_valid", int'(sel_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] chase up, dwell 3, steps 4");
        applyStimulus(2'b00, 8'd3, 5'd4);
        exp_q = '{0, 1, 2, 3};
        expectShow(3);

        $display("[TB] bounce, steps 0 then 20");
        applyStimulus(2'b10, 8'd1, 5'd0);
        exp_q = {};
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        expectShow(1);
        applyStimulus(2'b10, 8'd1, 5'd20);
        exp_q.push_back(14);
        exp_q.push_back(13);
        exp_q.push_back(12);
        exp_q.push_back(11);
        expectShow(1);

        $display("[TB] chase down, dwell 0, steps 3");
        applyStimulus(2'b01, 8'd0, 5'd3);
        exp_q = '{15, 14, 13};
        expectShow(1);

        $display("[TB] random mode straight after reset");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lfsr_model = 8'hA5;
        exp_q = {};
        for (int i = 0; i < 3; i++) begin
            lfsr_model = lfsrAdvance(lfsr_model);
            exp_q.push_back(int'(lfsr_model[3:0]));
        end
        applyStimulus(2'b11, 8'd1, 5'd3);
        expectShow(1);

        $display("[TB] abort during third channel");
        applyStimulus(2'b00, 8'd5, 5'd8);
        for (int i = 0; i < 11; i++) begin
            checkOutput("abort_pre_sel", int'(sel), i / 5);
            @(negedge clk);
        end
        checkOutput("abort_pre_sel", int'(sel), 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_sel_valid", int'(sel_valid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        checkOutput("abort_sel_hold", int'(sel), 2);
        @(negedge clk);
        checkOutput("abort_no_done", int'(done), 0);
        checkOutput("abort_idle_busy", int'(busy), 0);
        applyStimulus(2'b00, 8'd5, 5'd8);
        exp_q = '{0, 1, 2, 3, 4, 5, 6, 7};
        expectShow(5);

        $display("[TB] reset during a show");
        applyStimulus(2'b00, 8'd2, 5'd8);
        repeat (3) @(negedge clk);
        checkOutput("midrun_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrun_rst_sel", int'(sel), 0);
        checkOutput("midrun_rst_sel_valid", int'(sel_valid), 0);
        checkOutput("midrun_rst_busy", int'(busy), 0);
        checkOutput("midrun_rst_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] trigger held through a show");
        mode    = 2'b00;
        dwell   = 8'd2;
        steps   = 5'd3;
        trigger = 1'b1;
        @(negedge clk);
        exp_q = '{0, 1, 2};
        expectShow(2);
        @(negedge clk);
        checkOutput("retrigger_sel", int'(sel), 0);
        checkOutput("retrigger_sel_valid", int'(sel_valid), 1);
        checkOutput("retrigger_busy", int'(busy), 1);
        trigger = 1'b0;
        @(negedge clk);
        checkOutput("retrigger_hold_sel", int'(sel), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
